dvp_tx: RTL and testbench
=========================

DVP_TX -- requirements
Module: dvp_tx

Interface
REQ-001 Parameter WIDTH, default 1280: active pixels per line; multiple of 8.
REQ-002 Parameter HEIGHT, default 720: active lines per frame.
REQ-003 Parameters VS_LINES=3, VBP_LINES=17, VFP_LINES=10, HBLANK=16: vsync, back-porch and front-porch lines; blank pclk periods per line; all >=1.
REQ-004 clk  in  1  sole clock; single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  run request; sampled only at frame boundaries.
REQ-007 mode  in  1  pattern select: 0 = colour bars, 1 = coordinate pattern.
REQ-008 pclk  out  1  DVP pixel clock, clk/2, register-driven.
REQ-009 vsync  out  1  frame sync, active high.
REQ-010 href  out  1  line valid, active high.
REQ-011 data  out  8  RGB565 byte stream.
REQ-012 frame_done  out  1  one-clk pulse at end of each frame.
REQ-013 frame_cnt  out  16  completed-frame count, wraps 0xFFFF->0.

Function
REQ-014 pclk toggles every clk; vsync/href/data change only in the clk where pclk goes 1->0, so they are stable at pclk rising edges.
REQ-015 "One period" = one full pclk cycle = 2 clk; one line = 2*WIDTH+HBLANK periods.
REQ-016 FSM states IDLE, VSYNC, VBP, ACTIVE, VFP; IDLE->VSYNC at the first pclk falling edge with en=1.
REQ-017 VSYNC: vsync=1, href=0 for VS_LINES lines, then VBP.
REQ-018 VBP: vsync=0, href=0 for VBP_LINES lines, then ACTIVE.
REQ-019 ACTIVE: HEIGHT lines; each line href=1 for 2*WIDTH periods, then href=0 for HBLANK periods; then VFP.
REQ-020 VFP: href=0 for VFP_LINES lines; at exit frame_done=1 for one clk and frame_cnt increments in the same clk.
REQ-021 After VFP: en=1 -> VSYNC with no gap; en=0 -> IDLE; en changes mid-frame have no effect.
REQ-022 mode is latched on VSYNC entry and held for the whole frame.
REQ-023 Per pixel, high byte pix[15:8] first, then low byte pix[7:0]; data=0 whenever href=0.
REQ-024 Mode 0: 8 equal bars of WIDTH/8 pixels, left to right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; bar index from a bar-width counter, no divider.
REQ-025 Mode 1: pix = {y[7:0], x[7:0]}, with x = pixel index in line and y = active line index, both from 0.
REQ-026 Counters: byte/period counter ceil(log2(2*WIDTH+HBLANK)) bits; line counter sized for max(HEIGHT, VS_LINES, VBP_LINES, VFP_LINES); all clear at each state transition.

Reset
REQ-027 While rst=1: state=IDLE, pclk=0, vsync=0, href=0, data=0, frame_done=0, frame_cnt=0, and all counters cleared.
REQ-028 Reset mid-frame abandons the frame without a frame_done pulse; the next frame starts with a full VSYNC.

Structure
REQ-029 Package dvp_pkg holds pixel565_t (16 bit), the FSM state enum, and the 8 colour-bar constants.
REQ-030 Sub-module dvp_pattern (x, y, mode -> pixel565_t) is combinational; dvp_tx holds all timing.

Verification (WIDTH=16, HEIGHT=4, VS_LINES=1, VBP_LINES=2, VFP_LINES=1, HBLANK=4)
REQ-031 Reset release, en=1, mode=0 -> vsync high 36 periods, first href after 3 lines, 4 lines of 32 bytes, first bytes FF,FF,FF,FF, bytes 5-8 FF,E0,FF,E0, last two bytes 00,00.
REQ-032 mode=1 -> line 2 byte pair for x=5 is 02,05; frame_done pulses once per 8 lines (288 periods); frame_cnt=1 after the first frame.
REQ-033 en dropped mid-ACTIVE -> frame completes, frame_done pulses, then IDLE with all outputs 0; en=1 again -> new VSYNC.
REQ-034 mode toggled mid-frame -> pattern unchanged until the next frame.
REQ-035 rst pulsed mid-line -> next clk all outputs 0 and no frame_done; the next frame is complete and correctly timed.
REQ-036 Bench receiver samples on pclk rising edges and checks that no vsync/href/data transition coincides with a pclk rising edge.

Source files
------------

// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared types and constants for the DVP test-pattern transmitter
// Contents: pixel565_t, FSM state enum dvp_state_t, the eight colour-bar
// constants and a lookup from bar index to colour.
package dvp_pkg;

    typedef logic [15:0] pixel565_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } dvp_state_t;

    localparam pixel565_t BAR_WHITE   = 16'hFFFF;
    localparam pixel565_t BAR_YELLOW  = 16'hFFE0;
    localparam pixel565_t BAR_CYAN    = 16'h07FF;
    localparam pixel565_t BAR_GREEN   = 16'h07E0;
    localparam pixel565_t BAR_MAGENTA = 16'hF81F;
    localparam pixel565_t BAR_RED     = 16'hF800;
    localparam pixel565_t BAR_BLUE    = 16'h001F;
    localparam pixel565_t BAR_BLACK   = 16'h0000;

    function automatic pixel565_t bar_colour(input logic [2:0] idx);
        pixel565_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern.sv
// rtl/dvp_pattern.sv - combinational test-pattern pixel generator
// Ports: x, y      - pixel index in line / active line index (low 8 bits)
//        bar_idx   - colour-bar index, tracked by the timing counters
//        mode      - 0 = colour bars, 1 = coordinate pattern
//        pix       - RGB565 pixel
module dvp_pattern
    import dvp_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [2:0] bar_idx,
    input  logic       mode,
    output pixel565_t  pix
);

    always_comb begin
        if (mode) begin
            pix = {y, x};
        end else begin
            pix = bar_colour(bar_idx);
        end
    end

endmodule

// File: rtl/dvp_tx.sv
// rtl/dvp_tx.sv - DVP transmitter: frame/line timing plus test-pattern bytes
// Ports: clk, rst (sync, active high), en (run request), mode (pattern select)
//        pclk (clk/2), vsync, href, data[7:0] (RGB565 bytes, high byte first)
//        frame_done (one-clk pulse at frame end), frame_cnt[15:0]
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 720,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10,
    parameter int HBLANK    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mode,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int LINE_PER  = 2 * WIDTH + HBLANK;
    localparam int PER_W     = $clog2(LINE_PER);
    localparam int MAX_AB    = (HEIGHT > VS_LINES) ? HEIGHT : VS_LINES;
    localparam int MAX_CD    = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
    localparam int MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int BAR_PIX   = WIDTH / 8;
    localparam int BAR_CW    = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(LINE_PER - 1);
    localparam logic [PER_W-1:0]  HREF_END  = PER_W'(2 * WIDTH);
    localparam logic [BAR_CW-1:0] BAR_LAST  = BAR_CW'(BAR_PIX - 1);
    localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VS_LINES - 1);
    localparam logic [LINE_W-1:0] VBP_LAST  = LINE_W'(VBP_LINES - 1);
    localparam logic [LINE_W-1:0] ACT_LAST  = LINE_W'(HEIGHT - 1);
    localparam logic [LINE_W-1:0] VFP_LAST  = LINE_W'(VFP_LINES - 1);

    dvp_state_t        state_q, state_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] line_last;
    logic [BAR_CW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic              mode_q, mode_d;
    logic              pclk_q, pclk_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    pixel565_t         pix;

    always_comb begin
        case (state_q)
            ST_VSYNC:  line_last = VS_LAST;
            ST_VBP:    line_last = VBP_LAST;
            ST_ACTIVE: line_last = ACT_LAST;
            default:   line_last = VFP_LAST;
        endcase
    end

    // Timing: every counter and state move happens only in the clk where
    // pclk_q is 1, i.e. where pclk falls; the other clk is a hold cycle.
    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        line_d       = line_q;
        bar_cnt_d    = bar_cnt_q;
        bar_idx_d    = bar_idx_q;
        x_d          = x_q;
        y_d          = y_q;
        mode_d       = mode_q;
        pclk_d       = ~pclk_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (pclk_q) begin
            if (state_q == ST_IDLE) begin
                if (en) begin
                    state_d = ST_VSYNC;
                    per_d   = '0;
                    line_d  = '0;
                    y_d     = '0;
                    mode_d  = mode;
                end
            end else if (per_q != PER_LAST) begin
                per_d = per_q + 1'b1;
            end else begin
                per_d = '0;
                if (line_q != line_last) begin
                    line_d = line_q + 1'b1;
                    y_d    = y_q + 8'd1;
                end else begin
                    line_d = '0;
                    y_d    = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBP;
                        ST_VBP:    state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFP;
                        ST_VFP: begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                            if (en) begin
                                state_d = ST_VSYNC;
                                mode_d  = mode;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end

            // Pixel and bar counters track per_d: a new pixel starts at every
            // even period, and the bar index steps each BAR_PIX pixels.
            if (per_d == '0) begin
                x_d       = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (!per_d[0]) begin
                x_d = x_q + 8'd1;
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 1'b1;
                end
            end
        end
    end

    dvp_pattern u_pattern (
        .x       (x_d),
        .y       (y_d),
        .bar_idx (bar_idx_d),
        .mode    (mode_d),
        .pix     (pix)
    );

    // Outputs are registered from the next-state view so they settle in the
    // same clk as the pclk fall and are stable at the following rise.
    always_comb begin
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        if (pclk_q) begin
            vsync_d = (state_d == ST_VSYNC);
            href_d  = (state_d == ST_ACTIVE) && (per_d < HREF_END);
            if (href_d) begin
                data_d = per_d[0] ? pix[7:0] : pix[15:8];
            end else begin
                data_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            per_q        <= '0;
            line_q       <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= 1'b0;
            pclk_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            per_q        <= per_d;
            line_q       <= line_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mode_q       <= mode_d;
            pclk_q       <= pclk_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign pclk       = pclk_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_tx.sv
// tb/tb_dvp_tx.sv - self-checking bench for dvp_tx with a small frame geometry
module tb_dvp_tx;

    localparam int W   = 16;
    localparam int H   = 4;
    localparam int VS  = 1;
    localparam int VBP = 2;
    localparam int VFP = 1;
    localparam int HB  = 4;
    localparam int LP  = 2 * W + HB;
    localparam int FP  = LP * (VS + VBP + H + VFP);

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    logic       fv [FP];
    logic       fh [FP];
    logic [7:0] fdat [FP];

    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int fd_gap = 0;
    int fd_wide = 0;
    int glitch = 0;
    logic       m_p = 1'b0, m_v = 1'b0, m_h = 1'b0, m_fd = 1'b0;
    logic [7:0] m_d = 8'h00;

    dvp_tx #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .VS_LINES  (VS),
        .VBP_LINES (VBP),
        .VFP_LINES (VFP),
        .HBLANK    (HB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: frame_done pulses and any output change at a pclk rise.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_gap = cyc - fd_cyc;
            fd_cyc = cyc;
            if (m_fd) fd_wide = fd_wide + 1;
        end
        if (pclk && !m_p && (vsync !== m_v || href !== m_h || data !== m_d))
            glitch = glitch + 1;
        m_p  = pclk;
        m_v  = vsync;
        m_h  = href;
        m_d  = data;
        m_fd = frame_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bar_ref(input int b);
        case (b)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Return the outputs as seen at the next pclk rising edge.
    task automatic get_period(output logic v, output logic h, output logic [7:0] d);
        logic prev;
        bit   got;
        got  = 1'b0;
        prev = pclk;
        v = 1'b0; h = 1'b0; d = 8'h00;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (pclk && !prev) begin
                got = 1'b1;
                v = vsync; h = href; d = data;
            end
            prev = pclk;
        end
        if (!got) check("pclk_rise_timeout", 0, 1);
    endtask

    // Wait for the first vsync period, record one frame, compare with the model.
    task automatic capture_frame(input logic exp_mode, input int act_at, input int act);
        logic v, h;
        logic [7:0] d;
        int n, bad_t, bad_b, l, pos;
        logic ev, ea;
        logic [7:0] xb, yb, eb;
        logic [15:0] pix;
        n = 0;
        get_period(v, h, d);
        while (!v && n < 400) begin
            get_period(v, h, d);
            n++;
        end
        check("frame_vsync_start", v, 1);
        for (int p = 0; p < FP; p++) begin
            if (p > 0) get_period(v, h, d);
            fv[p] = v; fh[p] = h; fdat[p] = d;
            if (p == act_at) begin
                if (act == 1) mode = ~mode;
                if (act == 2) en = 1'b0;
            end
        end
        bad_t = 0; bad_b = 0;
        for (int p = 0; p < FP; p++) begin
            l   = p / LP;
            pos = p % LP;
            ev  = (l < VS);
            ea  = (l >= VS + VBP) && (l < VS + VBP + H) && (pos < 2 * W);
            xb  = 8'(pos / 2);
            yb  = 8'(l - (VS + VBP));
            pix = exp_mode ? {yb, xb} : bar_ref((pos / 2) / (W / 8));
            eb  = ea ? ((pos % 2 == 1) ? pix[7:0] : pix[15:8]) : 8'h00;
            if (fv[p] !== ev || fh[p] !== ea) bad_t++;
            if (fdat[p] !== eb) bad_b++;
        end
        check("frame_timing_bad_periods", bad_t, 0);
        check("frame_data_bad_bytes", bad_b, 0);
    endtask

    initial begin
        logic v, h;
        logic [7:0] d;
        int vs_n, href_n, first_h, nz, n, fd_before;

        rst = 1'b1; en = 1'b0; mode = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pclk", pclk, 0);
        check("rst_vsync", vsync, 0);
        check("rst_href", href, 0);
        check("rst_data", data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Frame A: colour bars; mode flipped mid-ACTIVE must not affect it.
        en = 1'b1; rst = 1'b0;
        capture_frame(1'b0, 150, 1);
        vs_n = 0; href_n = 0; first_h = -1;
        for (int p = 0; p < FP; p++) begin
            if (fv[p]) vs_n++;
            if (fh[p]) begin
                href_n++;
                if (first_h < 0) first_h = p;
            end
        end
        check("a_vsync_periods", vs_n, 36);
        check("a_first_href", first_h, 108);
        check("a_href_periods", href_n, 128);
        check("a_byte0", fdat[108], 8'hFF);
        check("a_byte3", fdat[111], 8'hFF);
        check("a_byte4", fdat[112], 8'hFF);
        check("a_byte5", fdat[113], 8'hE0);
        check("a_byte6", fdat[114], 8'hFF);
        check("a_byte7", fdat[115], 8'hE0);
        check("a_last_hi", fdat[246], 8'h00);
        check("a_last_lo", fdat[247], 8'h00);
        @(negedge clk);
        check("a_frame_done", frame_done, 1);
        check("a_frame_cnt", frame_cnt, 1);

        // Frame B: coordinate pattern (latched at entry); en dropped mid-ACTIVE.
        capture_frame(1'b1, 150, 2);
        check("b_x5_hi", fdat[190], 8'h02);
        check("b_x5_lo", fdat[191], 8'h05);
        @(negedge clk);
        check("b_frame_done", frame_done, 1);
        check("b_frame_cnt", frame_cnt, 2);

        // IDLE after the frame completes.
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            get_period(v, h, d);
            if (v || h || d != 8'h00) nz++;
        end
        check("idle_outputs_nonzero", nz, 0);
        check("idle_frame_cnt", frame_cnt, 2);
        check("frame_done_count", fd_cnt, 2);
        check("frame_done_gap_clks", fd_gap, 2 * FP);

        // Frame C: restart, then reset mid-line.
        mode = 1'b0; en = 1'b1;
        n = 0;
        get_period(v, h, d);
        while (!v && n < 40) begin
            get_period(v, h, d);
            n++;
        end
        check("c_restart_vsync", v, 1);
        for (int i = 0; i < 120; i++) get_period(v, h, d);
        check("c_mid_line_href", h, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pclk", pclk, 0);
        check("mid_rst_vsync", vsync, 0);
        check("mid_rst_href", href, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        fd_before = fd_cnt;

        // Frame D: full, correctly timed frame after the reset.
        capture_frame(1'b0, -1, 0);
        @(negedge clk);
        check("d_frame_done", frame_done, 1);
        check("d_frame_cnt", frame_cnt, 1);
        @(negedge clk);
        check("d_frame_done_count", fd_cnt, fd_before + 1);
        check("frame_done_wide", fd_wide, 0);
        check("edge_coincident_changes", glitch, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
